mdu_iter: RTL and testbench

- Iterative multiply/divide unit in the EX stage, alongside the combinational ALU. Owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
- Exposes a start/busy/done handshake. Hazard logic stalls on busy, and on MFHI/MFLO while busy.

---
 rtl/mdu_iter.sv | 199 +++++++++++++++++++
 tb/tb_mdu_iter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative MULT/DIV unit owning HI/LO: 33 busy cycles per mul/div (32 CALC + 1 FIX), MTHI/MTLO in one; start ignored while busy.
// MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (ops 7-10); without it codes 7-15 are NOPs.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int W = WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_ADD  = 2'd1;
    localparam logic [1:0] ACC_SUB  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t         state;
    logic [5:0]     cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   rem;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic [W-1:0]   a_raw;
    logic           is_div;
    logic           div_zero;
    logic           neg_res;
    logic           neg_rem;
    logic [1:0]     acc_mode;

    logic           dec_mul;
    logic           dec_div;
    logic           dec_sgn;
    logic [1:0]     dec_acc;

    always_comb begin
        dec_mul = 1'b0;
        dec_div = 1'b0;
        dec_sgn = 1'b0;
        dec_acc = ACC_NONE;
        case (MDUOp)
            OP_MULT:  begin dec_mul = 1'b1; dec_sgn = 1'b1; end
            OP_MULTU: dec_mul = 1'b1;
            OP_DIV:   begin dec_div = 1'b1; dec_sgn = 1'b1; end
            OP_DIVU:  dec_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = ACC_ADD; end
            OP_MADDU: begin dec_mul = 1'b1; dec_acc = ACC_ADD; end
            OP_MSUB:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = ACC_SUB; end
            OP_MSUBU: begin dec_mul = 1'b1; dec_acc = ACC_SUB; end
`endif
            default: ;
        endcase
    end

    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;

    assign a_neg = dec_sgn & A[W-1];
    assign b_neg = dec_sgn & B[W-1];
    assign mag_a = a_neg ? (~A + 1'b1) : A;
    assign mag_b = b_neg ? (~B + 1'b1) : B;

    // Multiply: upper half accumulates the multiplicand, lower half shifts out multiplier bits.
    logic [W:0]     mul_sum;
    assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opa} : {(W+1){1'b0}});

    // Divide: acc[W-1:0] shifts dividend bits out at the top and quotient bits in at the bottom.
    logic [W:0]     div_shift;
    logic           div_ok;
    logic [W-1:0]   div_diff;
    assign div_shift = {rem, acc[W-1]};
    assign div_ok    = div_shift >= {1'b0, opb};
    assign div_diff  = div_shift[W-1:0] - opb;

    logic [2*W-1:0] prod;
    logic [W-1:0]   quot;
    logic [W-1:0]   remv;
    assign prod = neg_res ? (~acc + 1'b1) : acc;
    assign quot = neg_res ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
    assign remv = neg_rem ? (~rem + 1'b1) : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            opa      <= '0;
            opb      <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            acc_mode <= ACC_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        if (MDUOp == OP_MTHI) begin
                            HI   <= A;
                            done <= 1'b1;
                        end else if (MDUOp == OP_MTLO) begin
                            LO   <= A;
                            done <= 1'b1;
                        end else if (dec_mul || dec_div) begin
                            state    <= S_CALC;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            is_div   <= dec_div;
                            acc_mode <= dec_acc;
                            opa      <= mag_a;
                            opb      <= mag_b;
                            a_raw    <= A;
                            div_zero <= (B == '0);
                            rem      <= '0;
                            acc      <= {{W{1'b0}}, (dec_div ? mag_a : mag_b)};
                            neg_res  <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                        end
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div) begin
                            rem <= div_ok ? div_diff : div_shift[W-1:0];
                            acc <= {acc[2*W-1:W], acc[W-2:0], div_ok};
                        end else begin
                            acc <= {mul_sum, acc[W-1:1]};
                        end
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'(ITER - 1))
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (is_div) begin
                            if (div_zero) begin
                                LO <= '1;
                                HI <= a_raw;
                            end else begin
                                LO <= quot;
                                HI <= remv;
                            end
                        end else begin
                            // Accumulating ops use whatever HI/LO hold at this edge.
                            case (acc_mode)
                                ACC_ADD: {HI, LO} <= {HI, LO} + prod;
                                ACC_SUB: {HI, LO} <= {HI, LO} - prod;
                                default: {HI, LO} <= prod;
                            endcase
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table for mul/div results plus sequences for MT*, cancel, reset and the accumulate ops.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec = 0;
    int n_bad = 0;

    mdu_iter #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .MDUOp(MDUOp), .A(A), .B(B),
        .cancel(cancel), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Issue a mul/div op, then check busy length, done pulse and HI/LO.
    task automatic run_md(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        @(negedge clk);
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        lat = 0;
        while (busy && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk({nm, ".latency"}, 32'(lat), 32'd33);
        chk({nm, ".done"}, {31'd0, done}, 32'd1);
        chk({nm, ".hi"}, HI, ehi);
        chk({nm, ".lo"}, LO, elo);
        @(negedge clk);
        chk({nm, ".done_end"}, {31'd0, done}, 32'd0);
    endtask

    task automatic mt(input string nm, input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; MDUOp = op; A = a;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        chk({nm, ".busy"}, {31'd0, busy}, 32'd0);
        chk({nm, ".done"}, {31'd0, done}, 32'd1);
        chk({nm, ".val"}, (op == 4'd5) ? HI : LO, a);
    endtask

    initial begin
        int k;
        int ndone;
        vt[0]  = '{4'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vt[1]  = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vt[2]  = '{4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vt[3]  = '{4'd4, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vt[4]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vt[5]  = '{4'd4, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vt[6]  = '{4'd1, 32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD};
        vt[7]  = '{4'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vt[8]  = '{4'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vt[9]  = '{4'd3, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};
        vt[10] = '{4'd3, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vt[11] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vt[12] = '{4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};

        rst = 1'b1; start = 1'b0; MDUOp = 4'd0; A = '0; B = '0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.hi", HI, 32'd0);
        chk("reset.lo", LO, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            run_md($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);

        // MTHI then a MTLO attempt while a DIV is in flight.
        mt("mthi", 4'd5, 32'h1234_5678);
        @(negedge clk);
        chk("mthi.done_end", {31'd0, done}, 32'd0);
        mt("mtlo", 4'd6, 32'h1111_1111);
        @(negedge clk);
        start = 1'b1; MDUOp = 4'd3; A = 32'h0000_0064; B = 32'h0000_0007;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("calc.lo_hold", LO, 32'h1111_1111);
        chk("calc.hi_hold", HI, 32'h1234_5678);
        start = 1'b1; MDUOp = 4'd6; A = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        chk("mtlo_busy.busy", {31'd0, busy}, 32'd1);
        k = 0;
        while (busy && k < 200) begin k++; @(negedge clk); end
        chk("mtlo_busy.done", {31'd0, done}, 32'd1);
        chk("mtlo_busy.lo", LO, 32'h0000_000E);
        chk("mtlo_busy.hi", HI, 32'h0000_0002);

        // Cancel mid-DIV: no commit, no done.
        mt("set_hi", 4'd5, 32'hAAAA_0000);
        mt("set_lo", 4'd6, 32'h0000_5555);
        @(negedge clk);
        start = 1'b1; MDUOp = 4'd3; A = 32'h0000_0100; B = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel.busy", {31'd0, busy}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("cancel.no_done", 32'(ndone), 32'd0);
        chk("cancel.hi", HI, 32'hAAAA_0000);
        chk("cancel.lo", LO, 32'h0000_5555);

        // Cancel together with start in IDLE drops the request.
        start = 1'b1; cancel = 1'b1; MDUOp = 4'd5; A = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; MDUOp = 4'd0;
        chk("cancel_idle.done", {31'd0, done}, 32'd0);
        chk("cancel_idle.hi", HI, 32'hAAAA_0000);

        // Reset in the middle of a MULT clears everything at once.
        start = 1'b1; MDUOp = 4'd1; A = 32'h0000_0003; B = 32'h0000_0005;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid.busy", {31'd0, busy}, 32'd0);
        chk("rst_mid.hi", HI, 32'd0);
        chk("rst_mid.lo", LO, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        chk("rst_mid.quiet", 32'(ndone), 32'd0);

`ifdef MDU_MADD_EN
        mt("madd_hi", 4'd5, 32'h0000_0000);
        mt("madd_lo", 4'd6, 32'hFFFF_FFFF);
        run_md("maddu", 4'd8, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000);
        run_md("msub", 4'd9, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF);
`else
        mt("nop_hi", 4'd5, 32'h0F0F_0F0F);
        mt("nop_lo", 4'd6, 32'hFFFF_FFFF);
        @(negedge clk);
        start = 1'b1; MDUOp = 4'd8; A = 32'h0000_0001; B = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        chk("nop8.busy", {31'd0, busy}, 32'd0);
        chk("nop8.done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("nop8.busy2", {31'd0, busy}, 32'd0);
        chk("nop8.hi", HI, 32'h0F0F_0F0F);
        chk("nop8.lo", LO, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
